// File: rtl/dft_bin_power_pkg.sv
// Shared DFT package: power-stage FSM states, derived-width helpers and the
// bin-count / accumulator-width defaults shared with the accumulation stage.
package dft_bin_power_pkg;

  localparam int DFT_NUM_BINS    = 16;
  localparam int DFT_ACCUM_WIDTH = 48;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SQUARE = 2'd1,
    EMIT   = 2'd2,
    REPORT = 2'd3
  } dft_power_state_t;

  // Operand width left after discarding the low accumulator bits.
  function automatic int dft_op_width(int accum_width, int drop_bits);
    return accum_width - drop_bits;
  endfunction

  // Exact width of re^2 + im^2 for signed operands of op_width bits.
  function automatic int dft_power_width(int op_width);
    return 2 * op_width + 1;
  endfunction

endpackage

// File: rtl/dft_bin_power_complex_mag_sq.sv
// complex_mag_sq: combinational re^2 + im^2, exact and unsigned.
module complex_mag_sq
  import dft_bin_power_pkg::*;
#(
  parameter  int IN_W  = 32,
  localparam int OUT_W = dft_power_width(IN_W)
) (
  input  logic signed [IN_W-1:0]  re_i,
  input  logic signed [IN_W-1:0]  im_i,
  output logic        [OUT_W-1:0] mag_sq_o
);

  logic signed [2*IN_W-1:0] re_sq;
  logic signed [2*IN_W-1:0] im_sq;

  // Squares are never negative, so the MSB is zero and zero-extension is exact.
  always_comb begin
    re_sq    = re_i * re_i;
    im_sq    = im_i * im_i;
    mag_sq_o = {1'b0, re_sq} + {1'b0, im_sq};
  end

endmodule

// File: rtl/dft_bin_power.sv
// dft_bin_power: snapshots all bin accumulators on the frame-done pulse,
// squares one bin at a time and streams |A[k]|^2 over valid/ready.
// Optional peak-bin tracker enabled by defining DFT_BIN_POWER_PEAK_EN.
module dft_bin_power
  import dft_bin_power_pkg::*;
#(
  parameter  int ACCUM_WIDTH = DFT_ACCUM_WIDTH,
  parameter  int NUM_BINS    = DFT_NUM_BINS,
  parameter  int DROP_BITS   = 16,
  localparam int OP_WIDTH    = dft_op_width(ACCUM_WIDTH, DROP_BITS),
  localparam int POWER_WIDTH = dft_power_width(OP_WIDTH),
  localparam int IDX_W       = $clog2(NUM_BINS)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          in_valid_i,
  input  logic signed [ACCUM_WIDTH-1:0] A_real_i [NUM_BINS],
  input  logic signed [ACCUM_WIDTH-1:0] A_imag_i [NUM_BINS],
  output logic                          pwr_valid_o,
  input  logic                          pwr_ready_i,
  output logic [POWER_WIDTH-1:0]        pwr_o,
  output logic [IDX_W-1:0]              bin_idx_o,
  output logic                          last_o,
  output logic                          busy_o,
  output logic                          overrun_o,
  output logic                          peak_valid_o,
  output logic [IDX_W-1:0]              peak_idx_o,
  output logic [POWER_WIDTH-1:0]        peak_pwr_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BINS - 1);

  dft_power_state_t state_q, state_d;
  logic [IDX_W-1:0]       k_q, k_d;
  logic [POWER_WIDTH-1:0] pwr_q, pwr_d;
  logic                   overrun_q, overrun_d;
  // Only the bits that survive the arithmetic shift are stored.
  logic signed [OP_WIDTH-1:0] snap_re_q [NUM_BINS];
  logic signed [OP_WIDTH-1:0] snap_re_d [NUM_BINS];
  logic signed [OP_WIDTH-1:0] snap_im_q [NUM_BINS];
  logic signed [OP_WIDTH-1:0] snap_im_d [NUM_BINS];
  logic [POWER_WIDTH-1:0] mag_sq;
  logic                   capture;
  logic                   accept;

  assign capture = (state_q == IDLE) && in_valid_i;
  assign accept  = (state_q == EMIT) && pwr_ready_i;

  complex_mag_sq #(
    .IN_W (OP_WIDTH)
  ) u_mag_sq (
    .re_i     (snap_re_q[k_q]),
    .im_i     (snap_im_q[k_q]),
    .mag_sq_o (mag_sq)
  );

  // Next-state, snapshot capture, bin index and power register update.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    pwr_d     = pwr_q;
    overrun_d = 1'b0;
    snap_re_d = snap_re_q;
    snap_im_d = snap_im_q;
    case (state_q)
      IDLE: begin
        if (capture) begin
          for (int unsigned i = 0; i < unsigned'(NUM_BINS); i++) begin
            snap_re_d[i] = A_real_i[i][ACCUM_WIDTH-1:DROP_BITS];
            snap_im_d[i] = A_imag_i[i][ACCUM_WIDTH-1:DROP_BITS];
          end
          k_d     = '0;
          state_d = SQUARE;
        end
      end
      SQUARE: begin
        pwr_d   = mag_sq;
        state_d = EMIT;
      end
      EMIT: begin
        if (accept) begin
          if (k_q == LAST_IDX) begin
`ifdef DFT_BIN_POWER_PEAK_EN
            state_d = REPORT;
`else
            state_d = IDLE;
`endif
          end else begin
            k_d     = k_q + IDX_W'(1);
            state_d = SQUARE;
          end
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (in_valid_i && (state_q != IDLE)) overrun_d = 1'b1;
  end

  // Main state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      k_q       <= '0;
      pwr_q     <= '0;
      overrun_q <= 1'b0;
      for (int unsigned i = 0; i < unsigned'(NUM_BINS); i++) begin
        snap_re_q[i] <= '0;
        snap_im_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      pwr_q     <= pwr_d;
      overrun_q <= overrun_d;
      snap_re_q <= snap_re_d;
      snap_im_q <= snap_im_d;
    end
  end

  assign pwr_valid_o = (state_q == EMIT);
  assign pwr_o       = pwr_q;
  assign bin_idx_o   = k_q;
  assign last_o      = pwr_valid_o && (k_q == LAST_IDX);
  assign busy_o      = (state_q != IDLE);
  assign overrun_o   = overrun_q;

`ifdef DFT_BIN_POWER_PEAK_EN
  logic [IDX_W-1:0]       trk_idx_q, trk_idx_d;
  logic [POWER_WIDTH-1:0] trk_pwr_q, trk_pwr_d;
  logic [IDX_W-1:0]       peak_idx_q, peak_idx_d;
  logic [POWER_WIDTH-1:0] peak_pwr_q, peak_pwr_d;

  // Running maximum (strict >, lowest index wins ties); the published peak is
  // loaded from the updated tracker so the final bin is included, and is kept
  // separate so it survives the tracker being cleared by the next capture.
  always_comb begin
    trk_idx_d  = trk_idx_q;
    trk_pwr_d  = trk_pwr_q;
    peak_idx_d = peak_idx_q;
    peak_pwr_d = peak_pwr_q;
    if (capture) begin
      trk_idx_d = '0;
      trk_pwr_d = '0;
    end else if (accept && (pwr_q > trk_pwr_q)) begin
      trk_idx_d = k_q;
      trk_pwr_d = pwr_q;
    end
    if (accept && (k_q == LAST_IDX)) begin
      peak_idx_d = trk_idx_d;
      peak_pwr_d = trk_pwr_d;
    end
  end

  // Peak tracker and published peak registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      trk_idx_q  <= '0;
      trk_pwr_q  <= '0;
      peak_idx_q <= '0;
      peak_pwr_q <= '0;
    end else begin
      trk_idx_q  <= trk_idx_d;
      trk_pwr_q  <= trk_pwr_d;
      peak_idx_q <= peak_idx_d;
      peak_pwr_q <= peak_pwr_d;
    end
  end

  assign peak_valid_o = (state_q == REPORT);
  assign peak_idx_o   = peak_idx_q;
  assign peak_pwr_o   = peak_pwr_q;
`else
  assign peak_valid_o = 1'b0;
  assign peak_idx_o   = '0;
  assign peak_pwr_o   = '0;
`endif

endmodule

// File: tb/tb_dft_bin_power.sv
// Directed self-checking bench for dft_bin_power (default 48/16/16 config).
// Peak expectations follow DFT_BIN_POWER_PEAK_EN when it is defined.
module tb_dft_bin_power;

  localparam int AW = 48;
  localparam int NB = 16;
  localparam int DB = 16;
  localparam int PW = 2 * (AW - DB) + 1;
  localparam int IW = 4;

  logic                 clk = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 in_valid = 1'b0;
  logic signed [AW-1:0] a_re [NB];
  logic signed [AW-1:0] a_im [NB];
  logic                 pwr_valid;
  logic                 pwr_ready = 1'b1;
  logic [PW-1:0]        pwr;
  logic [IW-1:0]        bin_idx;
  logic                 last;
  logic                 busy;
  logic                 overrun;
  logic                 peak_valid;
  logic [IW-1:0]        peak_idx;
  logic [PW-1:0]        peak_pwr;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  logic [79:0] exp_pwr [NB];
  int          exp_pk_idx;
  logic [79:0] exp_pk_pwr;

  dft_bin_power #(
    .ACCUM_WIDTH (AW),
    .NUM_BINS    (NB),
    .DROP_BITS   (DB)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .in_valid_i   (in_valid),
    .A_real_i     (a_re),
    .A_imag_i     (a_im),
    .pwr_valid_o  (pwr_valid),
    .pwr_ready_i  (pwr_ready),
    .pwr_o        (pwr),
    .bin_idx_o    (bin_idx),
    .last_o       (last),
    .busy_o       (busy),
    .overrun_o    (overrun),
    .peak_valid_o (peak_valid),
    .peak_idx_o   (peak_idx),
    .peak_pwr_o   (peak_pwr)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < NB; i++) begin
      a_re[i] = '0;
      a_im[i] = '0;
      exp_pwr[i] = '0;
    end
  endtask

  task automatic load_ramp();
    clear_inputs();
    for (int i = 0; i < NB; i++) begin
      a_re[i] = AW'(i * 65536);
      exp_pwr[i] = 80'(i * i);
    end
    exp_pk_idx = 15;
    exp_pk_pwr = 80'd225;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_valid"}, 80'(pwr_valid), 80'd0);
    chk({tag, "_pwr"}, 80'(pwr), 80'd0);
    chk({tag, "_idx"}, 80'(bin_idx), 80'd0);
    chk({tag, "_last"}, 80'(last), 80'd0);
    chk({tag, "_busy"}, 80'(busy), 80'd0);
    chk({tag, "_overrun"}, 80'(overrun), 80'd0);
    chk({tag, "_pkvalid"}, 80'(peak_valid), 80'd0);
    chk({tag, "_pkidx"}, 80'(peak_idx), 80'd0);
    chk({tag, "_pkpwr"}, 80'(peak_pwr), 80'd0);
  endtask

  // Runs one frame from the capture pulse; optional stall at one bin and an
  // optional second in_valid pulse at cycle ovr_cyc (capture cycle = 0).
  task automatic run_frame(input string tag, input int stall_bin, input int stall_len,
                           input int ovr_cyc);
    int c, got, stall, last_c;
    logic signed [AW-1:0] save_re0;
    save_re0 = a_re[0];
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    c = 1; got = 0; stall = 0; last_c = -1;
    chk({tag, "_busy_start"}, 80'(busy), 80'd1);
    chk({tag, "_valid_c1"}, 80'(pwr_valid), 80'd0);
    while (got < NB && c < 300) begin
      in_valid = (c == ovr_cyc);
      // Garbage on the inputs during the dropped pulse must not reach the snapshot.
      a_re[0] = (c == ovr_cyc) ? AW'(77 * 65536) : save_re0;
      if (ovr_cyc > 0 && (c == ovr_cyc + 1 || c == ovr_cyc + 2))
        chk({tag, "_overrun"}, 80'(overrun), 80'(c == ovr_cyc + 1));
      if (peak_valid) chk({tag, "_early_peak"}, 80'(peak_valid), 80'd0);
      if (pwr_valid) begin
        chk({tag, "_pwr"}, 80'(pwr), exp_pwr[got]);
        chk({tag, "_idx"}, 80'(bin_idx), 80'(got));
        chk({tag, "_last"}, 80'(last), 80'(got == NB - 1));
        if (got == stall_bin && stall < stall_len) begin
          pwr_ready = 1'b0;
          stall++;
        end else begin
          pwr_ready = 1'b1;
          got++;
          last_c = c;
        end
      end else begin
        pwr_ready = 1'b1;
      end
      tick();
      c++;
    end
    in_valid = 1'b0;
    pwr_ready = 1'b1;
    a_re[0] = save_re0;
    chk({tag, "_bins_done"}, 80'(got), 80'(NB));
    if (stall_len == 0) chk({tag, "_last_cycle"}, 80'(last_c), 80'(2 * NB));
`ifdef DFT_BIN_POWER_PEAK_EN
    chk({tag, "_pk_pulse"}, 80'(peak_valid), 80'd1);
    chk({tag, "_pk_idx"}, 80'(peak_idx), 80'(exp_pk_idx));
    chk({tag, "_pk_pwr"}, 80'(peak_pwr), exp_pk_pwr);
    chk({tag, "_busy_report"}, 80'(busy), 80'd1);
    tick();
    chk({tag, "_pk_pulse_end"}, 80'(peak_valid), 80'd0);
    chk({tag, "_pk_idx_hold"}, 80'(peak_idx), 80'(exp_pk_idx));
    chk({tag, "_pk_pwr_hold"}, 80'(peak_pwr), exp_pk_pwr);
`else
    chk({tag, "_pk_tied"}, 80'(peak_valid), 80'd0);
    chk({tag, "_pkidx_tied"}, 80'(peak_idx), 80'd0);
    chk({tag, "_pkpwr_tied"}, 80'(peak_pwr), 80'd0);
`endif
    chk({tag, "_idle"}, 80'(busy), 80'd0);
    chk({tag, "_valid_idle"}, 80'(pwr_valid), 80'd0);
  endtask

  initial begin
    int seen;
    clear_inputs();
    exp_pk_idx = 0;
    exp_pk_pwr = '0;

    // Reset state
    tick();
    tick();
    check_zero_outputs("reset");
    rst_ni = 1'b1;
    tick();
    check_zero_outputs("post_reset");

    // Ramp: power k^2, peak bin 15
    load_ramp();
    run_frame("ramp", -1, 0, 0);

    // Single complex bin: 3 - 4j gives 25
    clear_inputs();
    a_re[3] = AW'(3 * 65536);
    a_im[3] = AW'(-4 * 65536);
    exp_pwr[3] = 80'd25;
    exp_pk_idx = 3;
    exp_pk_pwr = 80'd25;
    run_frame("cplx", -1, 0, 0);

    // Tie at power 100 between bins 2 and 9: lowest index wins
    clear_inputs();
    a_re[2] = AW'(10 * 65536);
    a_re[9] = AW'(8 * 65536);
    a_im[9] = AW'(-6 * 65536);
    exp_pwr[2] = 80'd100;
    exp_pwr[9] = 80'd100;
    exp_pk_idx = 2;
    exp_pk_pwr = 80'd100;
    run_frame("tie", -1, 0, 0);

    // Backpressure: ready low 5 cycles while bin 4 is presented
    load_ramp();
    run_frame("stall", 4, 5, 0);

    // Second in_valid at cycle 5 is dropped
    load_ramp();
    run_frame("ovr", -1, 0, 5);

    // Reset mid-frame at bin 7
    load_ramp();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      if (pwr_valid && bin_idx == 4'd7) begin
        seen = 1;
        break;
      end
      tick();
    end
    chk("midrst_reach_bin7", 80'(seen), 80'd1);
    rst_ni = 1'b0;
    #1;
    check_zero_outputs("midrst");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst_no_peak", 80'(peak_valid), 80'd0);
    end
    rst_ni = 1'b1;
    tick();
    chk("midrst_idle_pk", 80'(peak_valid), 80'd0);
    chk("midrst_idle_busy", 80'(busy), 80'd0);
    run_frame("after_rst", -1, 0, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
